// File: rtl/apb_modport_pkg.sv
// apb_modport_pkg: register map, status bit positions, divisor default and UART FSM states
package apb_modport_pkg;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;
  localparam int ST_TX_BUSY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_RX_FRAME_ERR = 3;
  localparam logic [15:0] DIV_RESET_DEF = 16'd16;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;
endpackage

// File: rtl/apb_modport_if.sv
// apb_modport_if: APB3 bus signal bundle with master and slave views
interface apb_modport_if;
  logic PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSELx, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_modport_uart_rx.sv
// apb_modport_uart_rx: synchronised 8N1 receiver with valid/overrun/frame-error flags
module apb_modport_uart_rx
  import apb_modport_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [15:0] div_i,
  input  logic        rx_i,
  input  logic        rd_clr_i,
  input  logic        clr_ovr_i,
  input  logic        clr_ferr_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        ovr_o,
  output logic        ferr_o
);
  uart_state_e state_q;
  logic [2:0] sync_q;
  logic [15:0] div_q, cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q, data_q;
  logic valid_q, ovr_q, ferr_q;
  logic rx, fall, half, full, done;
  // sync_q[1:0] is the synchroniser, sync_q[2] the previous sample for edge detection
  always_comb begin
    rx = sync_q[1];
    fall = sync_q[2] & ~sync_q[1];
    half = cnt_q == (div_q >> 1) - 16'd1;
    full = cnt_q == div_q - 16'd1;
    done = (state_q == S_STOP) & full;
  end
  // RX FSM: start re-checked at mid-bit, data and stop sampled at mid-bit
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q <= S_IDLE;
      sync_q <= '1;
      div_q <= DIV_RESET_DEF;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
      cnt_q <= (state_q == S_IDLE || (state_q == S_START ? half : full)) ? '0 : cnt_q + 16'd1;
      case (state_q)
        S_IDLE: if (fall) begin
          state_q <= S_START;
          div_q <= div_i;
        end
        S_START: if (half) begin
          state_q <= rx ? S_IDLE : S_DATA;
          bit_q <= '0;
        end
        S_DATA: if (full) begin
          sh_q <= {rx, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= S_STOP;
        end
        default: if (full) state_q <= S_IDLE;
      endcase
    end
  // flags: a completing frame wins over a same-cycle read or W1C clear
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (done) data_q <= sh_q;
      valid_q <= done | (valid_q & ~rd_clr_i);
      ovr_q <= (done & valid_q) | (ovr_q & ~clr_ovr_i);
      ferr_q <= (done & ~rx) | (ferr_q & ~clr_ferr_i);
    end
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign ovr_o = ovr_q;
  assign ferr_o = ferr_q;
endmodule

// File: rtl/apb_modport.sv
// apb_modport: zero-wait-state APB3 slave exposing an 8N1 UART through four registers
module apb_modport
  import apb_modport_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = DIV_RESET_DEF
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  apb_modport_if.slave apb,
  input  logic         uart_rx,
  output logic         uart_tx
);
  uart_state_e tx_state_q;
  logic [15:0] baud_q, tx_div_q, tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q, rx_data;
  logic tx_q, acc, mis, err, ok_wr, rd, tx_busy, tx_wr, tx_end;
  logic rx_valid, rx_ovr, rx_ferr;
  logic [1:0] a;
  logic [3:0] status;
  logic [31:0] rdata;
  // bus decode: errors and read data are combinational in the access phase
  always_comb begin
    a = apb.PADDR[3:2];
    acc = apb.PSELx & apb.PENABLE;
    mis = |apb.PADDR[1:0];
    tx_busy = tx_state_q != S_IDLE;
    err = acc & (mis | (apb.PWRITE & (a == REG_TXDATA) & tx_busy)
               | (apb.PWRITE & (a == REG_BAUDDIV) & (apb.PWDATA[15:0] < 16'd2)));
    ok_wr = acc & apb.PWRITE & ~err;
    rd = acc & ~apb.PWRITE & ~mis;
    tx_wr = ok_wr & (a == REG_TXDATA);
    status = '0;
    status[ST_TX_BUSY] = tx_busy;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVERRUN] = rx_ovr;
    status[ST_RX_FRAME_ERR] = rx_ferr;
    rdata = a == REG_RXDATA ? {24'd0, rx_data} : a == REG_STATUS ? {28'd0, status} :
            a == REG_BAUDDIV ? {16'd0, baud_q} : '0;
    apb.PREADY = acc;
    apb.PSLVERR = err;
    apb.PRDATA = rd ? rdata : '0;
  end
  // divisor register: only error-free writes land
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) baud_q <= DIV_RESET;
    else if (ok_wr && a == REG_BAUDDIV) baud_q <= apb.PWDATA[15:0];
  assign tx_end = tx_cnt_q == tx_div_q - 16'd1;
  // TX FSM: the line is registered from the state, so it follows acceptance by one cycle
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      tx_state_q <= S_IDLE;
      tx_div_q <= DIV_RESET;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_q <= 1'b1;
    end else begin
      tx_q <= tx_state_q == S_START ? 1'b0 : tx_state_q == S_DATA ? tx_sh_q[0] : 1'b1;
      tx_cnt_q <= (tx_state_q == S_IDLE || tx_end) ? '0 : tx_cnt_q + 16'd1;
      case (tx_state_q)
        S_IDLE: if (tx_wr) begin
          tx_state_q <= S_START;
          tx_sh_q <= apb.PWDATA[7:0];
          tx_div_q <= baud_q;
        end
        S_START: if (tx_end) begin
          tx_state_q <= S_DATA;
          tx_bit_q <= '0;
        end
        S_DATA: if (tx_end) begin
          tx_sh_q <= tx_sh_q >> 1;
          tx_bit_q <= tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_q <= S_STOP;
        end
        default: if (tx_end) tx_state_q <= S_IDLE;
      endcase
    end
  assign uart_tx = tx_q;
  apb_modport_uart_rx u_rx (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .div_i     (baud_q),
    .rx_i      (uart_rx),
    .rd_clr_i  (rd && a == REG_RXDATA),
    .clr_ovr_i (ok_wr && a == REG_STATUS && apb.PWDATA[ST_RX_OVERRUN]),
    .clr_ferr_i(ok_wr && a == REG_STATUS && apb.PWDATA[ST_RX_FRAME_ERR]),
    .data_o    (rx_data),
    .valid_o   (rx_valid),
    .ovr_o     (rx_ovr),
    .ferr_o    (rx_ferr)
  );
endmodule

// File: tb/tb_apb_modport.sv
// tb_apb_modport: register vectors, TX waveform, loopback RX, flag and error corner cases
module tb_apb_modport;
  typedef struct {
    string name;
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] xd;
    logic xe;
  } vec_t;
  typedef struct {
    string name;
    logic [31:0] xd;
    logic xe;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, loop = 1'b0, rx_drv = 1'b1;
  logic tx, rx_line;
  int total = 0, bad = 0;
  exp_t sb[$];
  vec_t vecs[18];
  apb_modport_if bus();
  assign rx_line = loop ? tx : rx_drv;
  apb_modport #(.DIV_RESET(16'd16)) dut (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .apb    (bus),
    .uart_rx(rx_line),
    .uart_tx(tx)
  );
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [33:0] got, input logic [33:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  // scoreboard: each access phase is compared against the expectation queued at its setup
  always @(negedge clk)
    if (bus.PSELx && bus.PENABLE) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: addr %h", bus.PADDR);
      end else begin
        e = sb.pop_front();
        chk(e.name, {bus.PREADY, bus.PSLVERR, bus.PRDATA}, {1'b1, e.xe, e.xd});
      end
    end

  task automatic apb(input string n, input logic w, input logic [31:0] a, d, xd, input logic xe);
    @(posedge clk); #1;
    bus.PSELx = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = w;
    bus.PADDR = a;
    bus.PWDATA = d;
    sb.push_back('{n, xd, xe});
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSELx = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (16) @(posedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] fr;
    bus.PSELx = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
    vecs[0]  = '{"rst_status",   1'b0, 32'h8,        32'h0,        32'h0,  1'b0};
    vecs[1]  = '{"rst_bauddiv",  1'b0, 32'hC,        32'h0,        32'h10, 1'b0};
    vecs[2]  = '{"rst_rxdata",   1'b0, 32'h4,        32'h0,        32'h0,  1'b0};
    vecs[3]  = '{"txdata_rd",    1'b0, 32'h0,        32'h0,        32'h0,  1'b0};
    vecs[4]  = '{"baud_wr1",     1'b1, 32'hC,        32'h1,        32'h0,  1'b1};
    vecs[5]  = '{"baud_wr0",     1'b1, 32'hC,        32'h0,        32'h0,  1'b1};
    vecs[6]  = '{"baud_keep",    1'b0, 32'hC,        32'h0,        32'h10, 1'b0};
    vecs[7]  = '{"mis_rd",       1'b0, 32'h2,        32'h0,        32'h0,  1'b1};
    vecs[8]  = '{"mis_wr",       1'b1, 32'hE,        32'h5,        32'h0,  1'b1};
    vecs[9]  = '{"mis_no_fx",    1'b0, 32'hC,        32'h0,        32'h10, 1'b0};
    vecs[10] = '{"baud_wr2",     1'b1, 32'hC,        32'h2,        32'h0,  1'b0};
    vecs[11] = '{"baud_rd2",     1'b0, 32'hC,        32'h0,        32'h2,  1'b0};
    vecs[12] = '{"baud_hi_addr", 1'b1, 32'hF0C,      32'hABCD0010, 32'h0,  1'b0};
    vecs[13] = '{"baud_rd16",    1'b0, 32'hFFFFFFFC, 32'h0,        32'h10, 1'b0};
    vecs[14] = '{"status_wr",    1'b1, 32'h8,        32'hF,        32'h0,  1'b0};
    vecs[15] = '{"status_ro",    1'b0, 32'h8,        32'h0,        32'h0,  1'b0};
    vecs[16] = '{"rxdata_wr",    1'b1, 32'h4,        32'h55,       32'h0,  1'b0};
    vecs[17] = '{"rxdata_ro",    1'b0, 32'h4,        32'h0,        32'h0,  1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_tx", 34'(tx), 34'd1);
    chk("rst_pready", 34'(bus.PREADY), 34'd0);
    rst_n = 1'b1;
    foreach (vecs[i]) apb(vecs[i].name, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].xd, vecs[i].xe);

    fr = {1'b1, 8'hA5, 1'b0};
    apb("tx_a5", 1'b1, 32'h0, 32'hA5, 32'h0, 1'b0);
    apb("tx_busy_wr", 1'b1, 32'h0, 32'hFF, 32'h0, 1'b1);
    apb("tx_busy_st", 1'b0, 32'h8, 32'h0, 32'h1, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx_bit%0d", k), 34'(tx), 34'(fr[k]));
      repeat (16) @(negedge clk);
    end
    apb("tx_idle_st", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

    loop = 1'b1;
    apb("lb_tx", 1'b1, 32'h0, 32'h3C, 32'h0, 1'b0);
    repeat (180) @(posedge clk);
    apb("lb_status", 1'b0, 32'h8, 32'h0, 32'h2, 1'b0);
    apb("lb_rxdata", 1'b0, 32'h4, 32'h0, 32'h3C, 1'b0);
    apb("lb_cleared", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

    apb("ov_tx1", 1'b1, 32'h0, 32'h11, 32'h0, 1'b0);
    repeat (180) @(posedge clk);
    apb("ov_tx2", 1'b1, 32'h0, 32'h22, 32'h0, 1'b0);
    repeat (180) @(posedge clk);
    apb("ov_status", 1'b0, 32'h8, 32'h0, 32'h6, 1'b0);
    apb("ov_w1c", 1'b1, 32'h8, 32'h4, 32'h0, 1'b0);
    apb("ov_after", 1'b0, 32'h8, 32'h0, 32'h2, 1'b0);
    apb("ov_rxdata", 1'b0, 32'h4, 32'h0, 32'h22, 1'b0);
    apb("ov_cleared", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

    loop = 1'b0;
    send_rx(8'h81, 1'b0);
    repeat (40) @(posedge clk);
    apb("fe_status", 1'b0, 32'h8, 32'h0, 32'hA, 1'b0);
    apb("fe_rxdata", 1'b0, 32'h4, 32'h0, 32'h81, 1'b0);
    apb("fe_flag", 1'b0, 32'h8, 32'h0, 32'h8, 1'b0);
    apb("fe_w1c", 1'b1, 32'h8, 32'h8, 32'h0, 1'b0);
    apb("fe_cleared", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    apb("gl_status", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
    apb("gl_rxdata", 1'b0, 32'h4, 32'h0, 32'h81, 1'b0);

    apb("rs_baud", 1'b1, 32'hC, 32'h20, 32'h0, 1'b0);
    apb("rs_tx", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    chk("rs_tx_low", 34'(tx), 34'd0);
    #1 rst_n = 1'b0;
    #1 chk("rs_tx_idle", 34'(tx), 34'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb("rs_status", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
    apb("rs_baud_rd", 1'b0, 32'hC, 32'h0, 32'h10, 1'b0);
    repeat (2) @(posedge clk);
    chk("sb_drained", 34'(sb.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
